pc_source_ctrl: RTL and testbench
=================================

// Module: pc_source_ctrl
// PURPOSE
//  Multicycle sequencer that drives the next-PC mux select and the PC/EPC write enables.
//  Walks fetch -> decode -> one PC-update state per control-flow class.
//  Non-control-flow instructions are handed to the datapath control (exec_start/exec_done).
//  Sits between the instruction register decode fields and the PC-source mux / PC / EPC registers.
// PARAMETERS
//  FETCH_WAIT  2  memory read latency in cycles for an instruction fetch (>=1)
//  VEC_WAIT    2  memory read latency in cycles for an exception-vector load (>=1)
// PORTS
//  clk          in   1  single clock, rising edge
//  reset        in   1  asynchronous, active-high; forces state RESET
//  opcode       in   6  IR[31:26], valid from DECODE onward
//  funct        in   6  IR[5:0]
//  alu_zero     in   1  ALU zero flag, valid in BRANCH
//  overflow     in   1  ALU overflow, sampled only when exec_done=1
//  exec_done    in   1  datapath control finished current instruction
//  pc_source    out  3  select: 000 alu_result, 001 alu_out, 010 jump, 100 epc, 110 load_size
//  pc_write     out  1  PC load enable (one cycle)
//  ir_write     out  1  IR load enable
//  mem_read     out  1  memory read request (fetch or vector)
//  epc_write    out  1  EPC load enable
//  link_write   out  1  write PC into $ra (jal)
//  exec_start   out  1  one-cycle pulse handing off to datapath control
//  exc_cause    out  2  00 none, 01 invalid opcode, 10 overflow; held until next FETCH
// BEHAVIOUR
//  - Reset (async, active-high): state=RESET; all outputs 0, pc_source=000, counters 0.
//    RESET -> FETCH on the first edge after reset deasserts.
//  - All outputs are registered or Moore-decoded from state; no combinational input->output path,
//    except pc_write in BRANCH.
//  - FETCH: mem_read=1 for FETCH_WAIT cycles.
//    In the final cycle: ir_write=1, pc_write=1, pc_source=000 (PC<=PC+4). Then -> DECODE.
//  - DECODE (1 cycle, ALU forms branch target into alu_out). Dispatch:
//    - opc 0x04 beq / 0x05 bne -> BRANCH
//    - 0x02 j / 0x03 jal -> JUMP
//    - opc 0, funct 0x08 jr -> JR
//    - opc 0, funct 0x13 rte -> RTE
//    - opcode not in legal-opcode table -> EXC_SAVE, cause 01
//    - else -> EXEC (exec_start=1 on entry).
//  - BRANCH: pc_source=001; pc_write = beq ? alu_zero : ~alu_zero. -> FETCH.
//  - JUMP: pc_source=010, pc_write=1; link_write=1 iff jal. -> FETCH.
//  - JR: pc_source=000 (ALU passes rs), pc_write=1. -> FETCH.
//  - RTE: pc_source=100, pc_write=1. -> FETCH.
//  - EXEC: wait for exec_done, no timeout. On exec_done:
//    - overflow=1 -> EXC_SAVE, cause 10
//    - else -> FETCH.
//  - EXC_SAVE: epc_write=1 (EPC<=PC-4, datapath computes); mem_read=1 at vector address.
//    Held VEC_WAIT cycles; epc_write only in the first cycle. -> EXC_LOAD.
//  - EXC_LOAD: pc_source=110, pc_write=1. -> FETCH; exc_cause cleared on FETCH entry.
//  - overflow and exec_done are ignored in every state except EXEC; no nested exceptions.
//  - Wait counter: reloads on state entry, counts down, wraps never; width clog2(max wait)+1.
//  - Reset mid-instruction (any state): outputs 0 immediately; the partially updated PC is not restored.
//  - pc_source codes 011 and 111 are never driven.
// STRUCTURE
//  - Shared header pc_ctrl_defs.vh: pc_source codes, state encoding, opcode/funct constants,
//    exc_cause codes, legal-opcode list.
//  - One sub-module: wait_counter (load value, count-down, done flag), instanced once and shared
//    by FETCH and EXC_SAVE.
// TESTING
//  1. Reset held 3 cycles, release -> all outputs 0 during reset.
//     FETCH: mem_read=1 for 2 cycles, then ir_write=pc_write=1 with pc_source=000.
//  2. Branch, beq alu_zero=1 -> BRANCH: pc_source=001, pc_write=1.
//     beq alu_zero=0 -> pc_write=0. bne inverts both cases.
//  3. Jumps, opcode 0x03 jal -> pc_source=010, pc_write=1, link_write=1 for one cycle.
//     opcode 0x02 j -> link_write=0.
//  4. Invalid opcode, opcode 0x3F -> exc_cause=01, epc_write=1 for one cycle,
//     then EXC_LOAD with pc_source=110, pc_write=1, then FETCH.
//  5. Overflow: add, exec_done=1 with overflow=1 -> exc_cause=10, same EPC/vector sequence.
//     Then rte (opc 0, funct 0x13) -> pc_source=100, pc_write=1.
//  6. Reset asserted mid-EXC_SAVE -> outputs 0 within the same cycle, no EXC_LOAD.
//     Also: exec_done with overflow=1 pulsed during BRANCH -> ignored.

Source files
------------

// File: rtl/pc_source_ctrl_pkg.sv
// pc_source_ctrl_pkg: state, PC-source, opcode and exception encodings shared by the sequencer.
package pc_source_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_BRANCH,
        S_JUMP,
        S_JR,
        S_RTE,
        S_EXEC,
        S_EXC_SAVE,
        S_EXC_LOAD
    } state_t;

    localparam logic [2:0] PCS_ALU_RESULT = 3'b000;
    localparam logic [2:0] PCS_ALU_OUT    = 3'b001;
    localparam logic [2:0] PCS_JUMP       = 3'b010;
    localparam logic [2:0] PCS_EPC        = 3'b100;
    localparam logic [2:0] PCS_LOAD_SIZE  = 3'b110;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_RTE = 6'h13;

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_INVALID  = 2'b01;
    localparam logic [1:0] EXC_OVERFLOW = 2'b10;

    // R-type, jumps, branches, ALU immediates, loads and stores
    function automatic logic opcode_legal(input logic [5:0] opc);
        case (opc)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
            6'h28, 6'h29, 6'h2B: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic state_t dispatch(input logic [5:0] opc, input logic [5:0] fn);
        if (opc == OPC_BEQ || opc == OPC_BNE) return S_BRANCH;
        if (opc == OPC_J || opc == OPC_JAL) return S_JUMP;
        if (opc == OPC_RTYPE && fn == FN_JR) return S_JR;
        if (opc == OPC_RTYPE && fn == FN_RTE) return S_RTE;
        if (!opcode_legal(opc)) return S_EXC_SAVE;
        return S_EXEC;
    endfunction

endpackage

// File: rtl/pc_source_ctrl_wait_counter.sv
// pc_source_ctrl_wait_counter: loadable count-down timer that flags done at zero and never wraps.
module pc_source_ctrl_wait_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = load ? load_val : (count_q != '0) ? count_q - W'(1) : count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign done = count_q == '0;

endmodule

// File: rtl/pc_source_ctrl.sv
// pc_source_ctrl: multicycle sequencer driving the next-PC mux select and PC/EPC/IR write enables.
module pc_source_ctrl
    import pc_source_ctrl_pkg::*;
#(
    parameter int FETCH_WAIT = 2,
    parameter int VEC_WAIT   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       overflow,
    input  logic       exec_done,
    output logic [2:0] pc_source,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       epc_write,
    output logic       link_write,
    output logic       exec_start,
    output logic [1:0] exc_cause
);

    localparam int MAX_WAIT = FETCH_WAIT > VEC_WAIT ? FETCH_WAIT : VEC_WAIT;
    localparam int CW       = $clog2(MAX_WAIT) + 1;

    state_t        state_q, state_d;
    logic          entry_q, br_ne_q, jal_q;
    logic [1:0]    exc_cause_q, exc_cause_d;
    logic          cnt_load, cnt_done;
    logic [CW-1:0] cnt_val;

    // FETCH and EXC_SAVE never follow themselves, so any state change is a fresh entry
    assign cnt_load = state_d != state_q;
    assign cnt_val  = (state_d == S_EXC_SAVE) ? CW'(VEC_WAIT - 1) : CW'(FETCH_WAIT - 1);

    pc_source_ctrl_wait_counter #(.W(CW)) u_wait (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done     (cnt_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:    state_d = S_FETCH;
            S_FETCH:    state_d = cnt_done ? S_DECODE : S_FETCH;
            S_DECODE:   state_d = dispatch(opcode, funct);
            S_BRANCH,
            S_JUMP,
            S_JR,
            S_RTE,
            S_EXC_LOAD: state_d = S_FETCH;
            S_EXEC:     state_d = !exec_done ? S_EXEC : overflow ? S_EXC_SAVE : S_FETCH;
            S_EXC_SAVE: state_d = cnt_done ? S_EXC_LOAD : S_EXC_SAVE;
            default:    state_d = S_RESET;
        endcase
    end

    always_comb begin
        exc_cause_d = exc_cause_q;
        if (state_d == S_FETCH)
            exc_cause_d = EXC_NONE;
        else if (state_q == S_DECODE && state_d == S_EXC_SAVE)
            exc_cause_d = EXC_INVALID;
        else if (state_q == S_EXEC && state_d == S_EXC_SAVE)
            exc_cause_d = EXC_OVERFLOW;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_RESET;
            entry_q     <= 1'b0;
            br_ne_q     <= 1'b0;
            jal_q       <= 1'b0;
            exc_cause_q <= EXC_NONE;
        end else begin
            state_q     <= state_d;
            entry_q     <= cnt_load;
            exc_cause_q <= exc_cause_d;
            if (state_q == S_DECODE) begin
                br_ne_q <= opcode == OPC_BNE;
                jal_q   <= opcode == OPC_JAL;
            end
        end
    end

    // BRANCH is the only state whose pc_write follows an input (alu_zero) combinationally
    always_comb begin
        mem_read   = state_q == S_FETCH || state_q == S_EXC_SAVE;
        ir_write   = state_q == S_FETCH && cnt_done;
        pc_write   = (state_q == S_FETCH && cnt_done) ||
                     (state_q == S_BRANCH && (br_ne_q ^ alu_zero)) ||
                     state_q == S_JUMP || state_q == S_JR ||
                     state_q == S_RTE || state_q == S_EXC_LOAD;
        epc_write  = state_q == S_EXC_SAVE && entry_q;
        exec_start = state_q == S_EXEC && entry_q;
        link_write = state_q == S_JUMP && jal_q;
        exc_cause  = exc_cause_q;
        pc_source  = (state_q == S_BRANCH)   ? PCS_ALU_OUT :
                     (state_q == S_JUMP)     ? PCS_JUMP :
                     (state_q == S_RTE)      ? PCS_EPC :
                     (state_q == S_EXC_LOAD) ? PCS_LOAD_SIZE : PCS_ALU_RESULT;
    end

endmodule

// File: tb/tb_pc_source_ctrl.sv
// tb_pc_source_ctrl: randomized instruction stream with a cycle-level expected-output scoreboard.
module tb_pc_source_ctrl;

    localparam int FW = 2;
    localparam int VW = 2;

    typedef struct packed {
        logic [2:0] src;
        logic       pcw;
        logic       irw;
        logic       mr;
        logic       epcw;
        logic       lnk;
        logic       xs;
        logic [1:0] cause;
    } out_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0, funct = '0;
    logic       alu_zero = 1'b0, overflow = 1'b0, exec_done = 1'b0;
    logic [2:0] pc_source;
    logic       pc_write, ir_write, mem_read, epc_write, link_write, exec_start;
    logic [1:0] exc_cause;

    out_t       exp_q[$];
    int         n_tests = 0;
    int         n_fail = 0;
    logic [5:0] cur_opc = '0, cur_fn = '0;
    logic [5:0] legal [21] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                               6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
                               6'h28, 6'h29, 6'h2B};

    pc_source_ctrl #(.FETCH_WAIT(FW), .VEC_WAIT(VW)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .alu_zero   (alu_zero),
        .overflow   (overflow),
        .exec_done  (exec_done),
        .pc_source  (pc_source),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .epc_write  (epc_write),
        .link_write (link_write),
        .exec_start (exec_start),
        .exc_cause  (exc_cause)
    );

    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic out_t mk(input logic [2:0] s, input logic pw, iw, mr, ew, lw, xs,
                                input logic [1:0] c);
        return {s, pw, iw, mr, ew, lw, xs, c};
    endfunction

    function automatic logic is_legal(input logic [5:0] o);
        foreach (legal[i]) if (legal[i] == o) return 1'b1;
        return 1'b0;
    endfunction

    // one clock cycle: drive inputs just after the edge, record what the outputs must be
    task automatic cyc(input out_t e, input logic r, input logic az, ed, ov);
        @(posedge clk);
        #1;
        reset     = r;
        opcode    = cur_opc;
        funct     = cur_fn;
        alu_zero  = az;
        exec_done = ed;
        overflow  = ov;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cyc('0, 1'b1, rb(), rb(), rb());
        cyc('0, 1'b0, rb(), rb(), rb());
    endtask

    task automatic fetch_decode(input logic [5:0] o, f);
        cur_opc = o;
        cur_fn  = f;
        for (int i = 0; i < FW; i++)
            cyc(mk(3'b000, i == FW - 1, i == FW - 1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00), 1'b0, rb(), rb(), rb());
        cyc('0, 1'b0, rb(), rb(), rb());
    endtask

    task automatic exception(input logic [1:0] c);
        for (int i = 0; i < VW; i++)
            cyc(mk(3'b000, 1'b0, 1'b0, 1'b1, i == 0, 1'b0, 1'b0, c), 1'b0, rb(), rb(), rb());
        cyc(mk(3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c), 1'b0, rb(), rb(), rb());
    endtask

    // az_sel / ov_sel: 0 or 1 forces the value, 2 picks at random
    task automatic run_instr(input logic [5:0] o, f, input int az_sel, ov_sel);
        logic az, ov;
        int   d;
        az = az_sel > 1 ? rb() : 1'(az_sel);
        ov = ov_sel > 1 ? rb() : 1'(ov_sel);
        fetch_decode(o, f);
        if (o == 6'h04 || o == 6'h05)
            cyc(mk(3'b001, (o == 6'h04) ? az : !az, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00), 1'b0, az, 1'b1, 1'b1);
        else if (o == 6'h02 || o == 6'h03)
            cyc(mk(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, o == 6'h03, 1'b0, 2'b00), 1'b0, rb(), rb(), rb());
        else if (o == 6'h00 && f == 6'h08)
            cyc(mk(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00), 1'b0, rb(), rb(), rb());
        else if (o == 6'h00 && f == 6'h13)
            cyc(mk(3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00), 1'b0, rb(), rb(), rb());
        else if (!is_legal(o))
            exception(2'b01);
        else begin
            d = $urandom_range(0, 3);
            for (int i = 0; i <= d; i++)
                cyc(mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, i == 0, 2'b00), 1'b0, rb(), i == d,
                    (i == d) ? ov : rb());
            if (ov) exception(2'b10);
        end
    endtask

    task automatic reset_in_exc_save();
        fetch_decode(6'h3F, 6'h00);
        cyc('0, 1'b1, rb(), rb(), rb());
        do_reset(2);
    endtask

    initial begin : monitor
        out_t e, got;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                got = {pc_source, pc_write, ir_write, mem_read, epc_write, link_write, exec_start, exc_cause};
                n_tests++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL outputs@%0t {src,pcw,irw,mr,epcw,lnk,xs,cause} got=%b_%b%b%b%b%b%b_%b expected=%b_%b%b%b%b%b%b_%b",
                             $time, got.src, got.pcw, got.irw, got.mr, got.epcw, got.lnk, got.xs, got.cause,
                             e.src, e.pcw, e.irw, e.mr, e.epcw, e.lnk, e.xs, e.cause);
                end
            end
        end
    end

    initial begin : stimulus
        logic [5:0] o, f;
        do_reset(3);
        run_instr(6'h23, 6'h00, 2, 0);
        run_instr(6'h04, 6'h00, 1, 2);
        run_instr(6'h04, 6'h00, 0, 2);
        run_instr(6'h05, 6'h00, 1, 2);
        run_instr(6'h05, 6'h00, 0, 2);
        run_instr(6'h03, 6'h00, 2, 2);
        run_instr(6'h02, 6'h00, 2, 2);
        run_instr(6'h3F, 6'h00, 2, 2);
        run_instr(6'h00, 6'h20, 2, 1);
        run_instr(6'h00, 6'h13, 2, 2);
        run_instr(6'h00, 6'h08, 2, 2);
        reset_in_exc_save();
        run_instr(6'h00, 6'h20, 2, 1);
        run_instr(6'h08, 6'h00, 2, 0);
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 5))
                0:       o = 6'h00;
                1:       o = 6'($urandom_range(2, 5));
                2:       o = 6'h3F;
                3, 4:    o = legal[$urandom_range(0, 20)];
                default: o = 6'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       f = 6'h08;
                1:       f = 6'h13;
                2:       f = 6'h20;
                default: f = 6'($urandom);
            endcase
            run_instr(o, f, 2, 2);
            if ($urandom_range(0, 40) == 0) do_reset($urandom_range(1, 3));
        end
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected cycles left unchecked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
